// File: rtl/exit_status_reporter_pkg.sv
// Shared types and constants for the exit status reporter: UART bit-FSM states
// and the message layout "EXIT " + 8 hex digits + CR LF.
package exit_status_reporter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int          MSG_LEN     = 15;
    localparam logic [39:0] EXIT_PREFIX = "EXIT ";
    localparam logic [7:0]  CHAR_CR     = 8'h0D;
    localparam logic [7:0]  CHAR_LF     = 8'h0A;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // Byte idx of the report for a given captured value, most significant nibble first.
    function automatic logic [7:0] msg_byte(input logic [3:0] idx, input logic [31:0] value);
        if (idx < 4'd5)
            return EXIT_PREFIX[8*(4-int'(idx)) +: 8];
        if (idx < 4'd13)
            return hex_char(value[4*(12-int'(idx)) +: 4]);
        if (idx == 4'd13)
            return CHAR_CR;
        return CHAR_LF;
    endfunction

endpackage

// File: rtl/exit_status_reporter_uart_tx.sv
// 8N1 serialiser: takes one byte per valid/ready handshake and chains bytes
// back-to-back when the next byte is offered at the end of the stop bit.
//   state    | meaning
//   ST_IDLE  | line idle high, ready for a byte
//   ST_START | start bit (0)
//   ST_DATA  | eight data bits, LSB first
//   ST_STOP  | stop bit (1); last cycle accepts the next byte
module uart_tx_8n1
    import exit_status_reporter_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk_gen,
    input  logic       rst_n,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       done,
    output logic       tx
);

    localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_end;
    logic             tx_bit;
    logic             tx_q;

    assign bit_end = (cnt == '0);

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (valid) state_nxt = ST_START;
            ST_START: if (bit_end) state_nxt = ST_DATA;
            ST_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = ST_STOP;
            ST_STOP:  if (bit_end) state_nxt = valid ? ST_START : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready  = (state == ST_IDLE) || (state == ST_STOP && bit_end);
        done   = (state == ST_STOP) && bit_end;
        tx_bit = 1'b1;
        case (state)
            ST_START: tx_bit = 1'b0;
            ST_DATA:  tx_bit = shreg[0];
            default:  tx_bit = 1'b1;
        endcase
    end

    // Line is registered from the state so every bit lasts a full CLKS_PER_BIT on the pin.
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            tx_q <= tx_bit;
            if (state_nxt != ST_IDLE && (state == ST_IDLE || bit_end))
                cnt <= CNT_LOAD;
            else if (!bit_end)
                cnt <= cnt - CNT_W'(1);
            if (valid && ready)
                shreg <= data;
            else if (state == ST_DATA && bit_end)
                shreg <= {1'b0, shreg[7:1]};
            if (state == ST_DATA && bit_end)
                bit_idx <= bit_idx + 3'd1;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/exit_status_reporter.sv
// Reports the program exit code over UART as "EXIT hhhhhhhh\r\n" on each
// rising edge of exit_valid_i, and latches pass/fail LEDs from the code.
module exit_status_reporter
    import exit_status_reporter_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 20000000,
    parameter int BAUD_RATE   = 115200
) (
    input  logic        clk_gen,
    input  logic        rst_n,
    input  logic        exit_valid_i,
    input  logic [31:0] exit_value_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        pass_led_o,
    output logic        fail_led_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

    logic        valid_q;
    logic        busy_q;
    logic        pass_q;
    logic        fail_q;
    logic [3:0]  byte_idx;
    logic [31:0] value_q;
    logic        accept;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_done;
    logic [7:0]  tx_data;

    assign accept   = exit_valid_i && !valid_q && !busy_q;
    // Byte 0 goes straight into the serialiser on the capture edge; it does not depend on the value.
    assign tx_valid = accept || (busy_q && byte_idx != 4'(MSG_LEN));
    assign tx_data  = accept ? msg_byte(4'd0, exit_value_i) : msg_byte(byte_idx, value_q);

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            byte_idx <= 4'd0;
            value_q  <= 32'h0;
        end else begin
            valid_q <= exit_valid_i;
            if (accept) begin
                busy_q   <= 1'b1;
                value_q  <= exit_value_i;
                byte_idx <= 4'd1;
                pass_q   <= (exit_value_i == 32'h0);
                fail_q   <= (exit_value_i != 32'h0);
            end else if (busy_q) begin
                if (tx_valid && tx_ready)
                    byte_idx <= byte_idx + 4'd1;
                if (tx_done && byte_idx == 4'(MSG_LEN))
                    busy_q <= 1'b0;
            end
        end
    end

    uart_tx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk_gen (clk_gen),
        .rst_n   (rst_n),
        .valid   (tx_valid),
        .data    (tx_data),
        .ready   (tx_ready),
        .done    (tx_done),
        .tx      (tx_o)
    );

    assign busy_o     = busy_q;
    assign pass_led_o = pass_q;
    assign fail_led_o = fail_q;

endmodule

// File: tb/tb_exit_status_reporter.sv
// Scoreboard bench: stimulus queues the expected bytes, a UART monitor decodes tx_o
// and compares each byte, its framing and the start-bit spacing.
module tb_exit_status_reporter;

    logic        clk_gen      = 1'b0;
    logic        rst_n        = 1'b0;
    logic        exit_valid_i = 1'b0;
    logic [31:0] exit_value_i = 32'h0;
    logic        tx_o;
    logic        busy_o;
    logic        pass_led_o;
    logic        fail_led_o;

    exit_status_reporter #(
        .CLK_FREQ_HZ(1000000),
        .BAUD_RATE  (100000)
    ) dut (
        .clk_gen      (clk_gen),
        .rst_n        (rst_n),
        .exit_valid_i (exit_valid_i),
        .exit_value_i (exit_value_i),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .pass_led_o   (pass_led_o),
        .fail_led_o   (fail_led_o)
    );

    always #5 clk_gen = ~clk_gen;

    typedef struct {
        logic [7:0] b;
        bit         first;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clk_gen) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_msg(input string s, input bit crlf);
        exp_t e;
        for (int i = 0; i < s.len(); i++) begin
            e.b     = s[i];
            e.first = (i == 0);
            exp_q.push_back(e);
        end
        if (crlf) begin
            e.first = 1'b0;
            e.b = 8'h0D; exp_q.push_back(e);
            e.b = 8'h0A; exp_q.push_back(e);
        end
    endtask

    // Monitor: detects each start bit on tx_o and samples bit centres.
    initial begin : uart_monitor
        logic prev;
        int   last_t0;
        prev    = 1'b1;
        last_t0 = 0;
        forever begin
            @(negedge clk_gen);
            if (rst_n && prev && !tx_o) begin
                int         t0;
                logic [7:0] b;
                logic       start_ok;
                logic       stop_ok;
                exp_t       e;
                t0       = cyc;
                b        = 8'h00;
                start_ok = 1'b1;
                stop_ok  = 1'b1;
                for (int off = 1; off < 100; off++) begin
                    @(negedge clk_gen);
                    if (off == 5) start_ok = !tx_o;
                    if (off >= 15 && off <= 85 && (off % 10) == 5) b[(off-15)/10] = tx_o;
                    if (off >= 90) stop_ok = stop_ok & tx_o;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h required no byte (cycle %0d)", b, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_byte", {24'h0, b}, {24'h0, e.b});
                    check("start_bit", {31'h0, start_ok}, 32'd1);
                    check("stop_bit_10cyc", {31'h0, stop_ok}, 32'd1);
                    if (!e.first) check("start_spacing", t0 - last_t0, 32'd100);
                end
                last_t0 = t0;
            end
            prev = tx_o;
        end
    end

    task automatic fire(input logic [31:0] v, input string s, input bit crlf, input bit now);
        if (!now) @(negedge clk_gen);
        exit_value_i = v;
        exit_valid_i = 1'b1;
        push_msg(s, crlf);
        @(negedge clk_gen);
        check("busy_rise", {31'h0, busy_o}, 32'd1);
        check("tx_high_at_capture", {31'h0, tx_o}, 32'd1);
        check("pass_led", {31'h0, pass_led_o}, {31'h0, v == 32'h0});
        check("fail_led", {31'h0, fail_led_o}, {31'h0, v != 32'h0});
        exit_value_i = ~v;
        @(negedge clk_gen);
        check("start_latency", {31'h0, tx_o}, 32'd0);
    endtask

    // Counts busy cycles; optional actions fire at given busy-cycle counts.
    task automatic run_busy(input int start, input int toggle_at, input int raise_at,
                            input int rst_at, output int n);
        n = start;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk_gen);
            if (!busy_o) return;
            n++;
            if (n == toggle_at) exit_valid_i = 1'b0;
            if (n == toggle_at + 1) begin exit_valid_i = 1'b1; exit_value_i = 32'hFFFF_FFFF; end
            if (n == toggle_at + 2) exit_valid_i = 1'b0;
            if (n == raise_at) begin exit_valid_i = 1'b1; exit_value_i = 32'h0; end
            if (n == rst_at) begin rst_n = 1'b0; exit_valid_i = 1'b0; return; end
        end
        checks++;
        errors++;
        $display("FAIL busy_timeout: busy still high after %0d cycles, required fall at 1500", n);
    endtask

    task automatic drain_check();
        repeat (20) @(negedge clk_gen);
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin : stimulus
        int  n;
        bit  hi_ok;
        repeat (3) @(negedge clk_gen);
        check("rst_tx", {31'h0, tx_o}, 32'd1);
        check("rst_busy", {31'h0, busy_o}, 32'd0);
        check("rst_pass", {31'h0, pass_led_o}, 32'd0);
        check("rst_fail", {31'h0, fail_led_o}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_gen);
        check("idle_tx", {31'h0, tx_o}, 32'd1);

        // Pass report
        fire(32'h0000_0000, "EXIT 00000000", 1'b1, 1'b0);
        run_busy(2, -1, -1, -1, n);
        check("busy_len_pass", n, 32'd1500);
        check("pass_led_hold", {31'h0, pass_led_o}, 32'd1);
        check("fail_led_hold", {31'h0, fail_led_o}, 32'd0);
        exit_valid_i = 1'b0;
        drain_check();

        // Fail report
        fire(32'hDEAD_BEEF, "EXIT DEADBEEF", 1'b1, 1'b0);
        run_busy(2, -1, -1, -1, n);
        check("busy_len_fail", n, 32'd1500);
        check("pass_led_hold", {31'h0, pass_led_o}, 32'd0);
        check("fail_led_hold", {31'h0, fail_led_o}, 32'd1);
        exit_valid_i = 1'b0;
        drain_check();

        // Retrigger mid-message ignored, edge one cycle after busy fall accepted
        fire(32'h0000_0001, "EXIT 00000001", 1'b1, 1'b0);
        run_busy(2, 500, -1, -1, n);
        check("busy_len_retrig", n, 32'd1500);
        check("retrig_pass_led", {31'h0, pass_led_o}, 32'd0);
        check("retrig_fail_led", {31'h0, fail_led_o}, 32'd1);
        fire(32'h0000_0002, "EXIT 00000002", 1'b1, 1'b1);
        // Rising edge coincident with busy fall is ignored
        run_busy(2, -1, 1500, -1, n);
        check("busy_len_second", n, 32'd1500);
        repeat (3) @(negedge clk_gen);
        check("same_edge_ignored_busy", {31'h0, busy_o}, 32'd0);
        check("same_edge_ignored_pass", {31'h0, pass_led_o}, 32'd0);
        check("same_edge_ignored_fail", {31'h0, fail_led_o}, 32'd1);
        exit_valid_i = 1'b0;
        drain_check();

        // Level held high: one message only
        fire(32'h0000_ABCD, "EXIT 0000ABCD", 1'b1, 1'b0);
        run_busy(2, -1, -1, -1, n);
        check("busy_len_level", n, 32'd1500);
        repeat (3500) @(negedge clk_gen);
        check("level_no_retrigger", {31'h0, busy_o}, 32'd0);
        check("queue_drained_level", exp_q.size(), 32'd0);
        exit_valid_i = 1'b0;
        repeat (5) @(negedge clk_gen);

        // Reset at busy cycle 700 aborts the message
        fire(32'h1234_5678, "EXIT 12", 1'b0, 1'b0);
        run_busy(2, -1, -1, 700, n);
        #1;
        check("abort_tx", {31'h0, tx_o}, 32'd1);
        check("abort_busy", {31'h0, busy_o}, 32'd0);
        check("abort_pass", {31'h0, pass_led_o}, 32'd0);
        check("abort_fail", {31'h0, fail_led_o}, 32'd0);
        repeat (3) @(negedge clk_gen);
        rst_n = 1'b1;
        hi_ok = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_gen);
            hi_ok = hi_ok & tx_o & !busy_o;
        end
        check("no_resume_after_reset", {31'h0, hi_ok}, 32'd1);
        check("queue_drained_abort", exp_q.size(), 32'd0);

        // Valid already high at the first edge after reset release
        @(negedge clk_gen);
        rst_n        = 1'b0;
        exit_valid_i = 1'b1;
        exit_value_i = 32'h0000_0007;
        push_msg("EXIT 00000007", 1'b1);
        @(negedge clk_gen);
        rst_n = 1'b1;
        @(negedge clk_gen);
        check("post_reset_trigger", {31'h0, busy_o}, 32'd1);
        check("post_reset_fail_led", {31'h0, fail_led_o}, 32'd1);
        run_busy(1, -1, -1, -1, n);
        check("busy_len_post_reset", n, 32'd1500);
        exit_valid_i = 1'b0;
        drain_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exit_status_reporter.md
EXIT_STATUS_REPORTER -- requirements
Module: exit_status_reporter

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 20000000, frequency of clk_gen in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, UART bit rate.
REQ-003 clk_gen  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 exit_valid_i  input  1  program-finished flag from x_heep_system, synchronous to clk_gen.
REQ-006 exit_value_i  input  32  program exit code, qualified by exit_valid_i.
REQ-007 tx_o  output  1  UART 8N1 serial line; idle high.
REQ-008 busy_o  output  1  high while a report message is being transmitted.
REQ-009 pass_led_o  output  1  high after a report whose captured value is 0.
REQ-010 fail_led_o  output  1  high after a report whose captured value is non-zero.

Function
REQ-011 CLKS_PER_BIT SHALL be CLK_FREQ_HZ/BAUD_RATE with integer truncation; every bit lasts exactly CLKS_PER_BIT cycles.
REQ-012 A trigger SHALL be a rising edge of exit_valid_i: high at edge N and low at edge N-1, detected with one internal register.
REQ-013 On a trigger at edge N with busy_o low, the block SHALL capture exit_value_i at edge N, assert busy_o, and drive tx_o low (start bit of byte 0) from edge N+1.
REQ-014 A trigger while busy_o is high SHALL be ignored; a level held high SHALL NOT retrigger.
REQ-015 The message SHALL be 15 bytes: ASCII "EXIT ", eight uppercase hex digits of the captured value, most significant nibble first, then 0x0D, 0x0A.
REQ-016 Each byte SHALL be sent as one start bit (0), eight data bits LSB first, and one stop bit (1), with no idle gap between bytes.
REQ-017 FSM states: IDLE, START, DATA, STOP. IDLE->START on an accepted trigger; START->DATA after one bit time; DATA->STOP after eight bit times; STOP->START if bytes remain, else STOP->IDLE.
REQ-018 busy_o SHALL fall at the edge that ends the stop bit of byte 14; the total busy time is 150*CLKS_PER_BIT cycles.
REQ-019 A trigger on the same edge that busy_o falls SHALL be ignored; a trigger one edge later SHALL be accepted.
REQ-020 The LED outputs SHALL update at the capture edge: pass_led_o = (value==0), fail_led_o = (value!=0). They are mutually exclusive and hold until the next accepted trigger or reset.
REQ-021 The nibble-to-ASCII mapping SHALL be 0-9 to 0x30-0x39 and A-F to 0x41-0x46.

Reset
REQ-022 While rst_n is low: tx_o=1, busy_o=0, pass_led_o=0, fail_led_o=0, FSM in IDLE, counters and captured value at 0, edge register at 0.
REQ-023 Reset asserted mid-message SHALL abort transmission immediately (tx_o high asynchronously); no partial message resumes after reset release.
REQ-024 If exit_valid_i is already high at the first edge after reset release, that edge SHALL count as a trigger.

Structure
REQ-025 Package exit_status_reporter_pkg SHALL hold the FSM state enum, the MSG_LEN=15 constant, and the "EXIT " prefix/CR/LF byte constants.
REQ-026 A sub-module uart_tx_8n1 SHALL serialise one byte per valid/ready handshake; exit_status_reporter sequences message bytes into it.
REQ-027 The block SHALL be instantiated in the FPGA top on clk_gen/rst_n, consuming the full 32-bit exit value and exit_valid_o from x_heep_system.

Verification (CLK_FREQ_HZ=1000000, BAUD_RATE=100000, so 10 clocks per bit)
REQ-028 Pass case: exit_value_i=0x00000000 with a rising edge of exit_valid_i -> "EXIT 00000000\r\n" decoded on tx_o, busy_o high for exactly 1500 cycles, pass_led_o=1, fail_led_o=0.
REQ-029 Fail case: exit_value_i=0xDEADBEEF -> "EXIT DEADBEEF\r\n" decoded, fail_led_o=1, pass_led_o=0; tx_o goes low exactly 1 cycle after the capture edge.
REQ-030 Retrigger: toggle exit_valid_i low/high at cycle 500 of a report with value 0x1 -> ignored, one message only, LEDs unchanged; a new edge at busy-fall+1 -> second message sent.
REQ-031 Level hold: exit_valid_i held high for 5000 cycles -> exactly one message.
REQ-032 Reset mid-message: assert rst_n low at cycle 700 of a report -> tx_o=1, busy_o=0, both LEDs 0 immediately; after release with exit_valid_i low, tx_o stays high.
REQ-033 Bit timing: every start-bit falling edge is spaced 100 cycles apart across all 15 bytes, and the stop bits are high for 10 cycles.
